// File: rtl/can_fd_crc_check_if.sv
// Bus interface for the CAN FD receive-side CRC-field checker.
// The master side drives the bit stream and the frame context, and the
// slave side (the checker) returns the parse status and error flags.
interface can_fd_crc_check_if;
    logic        sample_point;
    logic        rx_bit;
    logic        start;
    logic        abort;
    logic        fd_frame;
    logic        fd_iso;
    logic [3:0]  dlc;
    logic [2:0]  stuff_cnt_in;
    logic [14:0] crc_15;
    logic [16:0] crc_17;
    logic [20:0] crc_21;
    logic        busy;
    logic        done;
    logic        crc_err;
    logic        stuff_cnt_err;
    logic        fsb_err;
    logic [4:0]  crc_len;

    modport master (
        output sample_point, rx_bit, start, abort, fd_frame, fd_iso, dlc,
               stuff_cnt_in, crc_15, crc_17, crc_21,
        input  busy, done, crc_err, stuff_cnt_err, fsb_err, crc_len
    );

    modport slave (
        input  sample_point, rx_bit, start, abort, fd_frame, fd_iso, dlc,
               stuff_cnt_in, crc_15, crc_17, crc_21,
        output busy, done, crc_err, stuff_cnt_err, fsb_err, crc_len
    );
endinterface

// File: rtl/can_fd_crc_check.sv
// CAN / CAN FD receive-side CRC-field checker.
// At start it freezes the calculated CRCs and picks CRC15/17/21. It then
// parses the CRC field (FD stuff count + parity, fixed stuff bits and CRC
// bits) and reports CRC, stuff-count and fixed-stuff-bit errors.
// Optional feature macro: CAN_STUFF_CNT_CHECK_EN enables the comparison of
// the received stuff count and parity against the destuffer's count.
module can_fd_crc_check #(
    parameter int FSB_PERIOD = 4
) (
    input logic               clk,
    input logic               rst_n,
    can_fd_crc_check_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_FSB, S_SCNT, S_PAR, S_CRC, S_DONE} state_t;

    state_t      r_state;
    logic        r_prev_bit;
    logic        r_fd;
    logic        r_iso;
    logic [20:0] r_crc_snap;
    logic [20:0] r_rx;
    logic [4:0]  r_crc_len;
    logic [4:0]  r_bits_left;
    logic [4:0]  r_field_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_crc_err;
    logic        r_fsb_err;
`ifdef CAN_STUFF_CNT_CHECK_EN
    logic [2:0]  r_cnt_gray;
    logic [2:0]  r_rx_cnt;
    logic        r_rx_par;
    logic        r_stuff_err;
`endif

    logic [4:0]  w_len;
    logic [20:0] w_snap;
    logic [4:0]  w_next_idx;
    logic        w_next_fsb;

    // Field-bit kind for a given field index: ISO frames lead with 3 stuff
    // count bits and a parity bit, everything after that is CRC.
    function automatic state_t field_state(input logic iso, input logic [4:0] idx);
        if (iso && idx < 5'd3)       return S_SCNT;
        else if (iso && idx == 5'd3) return S_PAR;
        else                         return S_CRC;
    endfunction

`ifdef CAN_STUFF_CNT_CHECK_EN
    function automatic logic [2:0] to_gray(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction
`endif

    assign w_next_idx = r_field_idx + 5'd1;
    assign w_next_fsb = r_fd && ((int'(w_next_idx) % FSB_PERIOD) == 0);

    // CRC selection from the frame context presented with start.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_len  = 5'd15;
        w_snap = {6'd0, bus.crc_15};
        if (bus.fd_frame) begin
            if (bus.dlc <= 4'd10) begin
                w_len  = 5'd17;
                w_snap = {4'd0, bus.crc_17};
            end else begin
                w_len  = 5'd21;
                w_snap = bus.crc_21;
            end
        end
    end

    // CRC-field parser: snapshots at start, consumes one bit per sample_point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_prev_bit  <= 1'b1;
            r_fd        <= 1'b0;
            r_iso       <= 1'b0;
            r_crc_snap  <= '0;
            r_rx        <= '0;
            r_crc_len   <= 5'd15;
            r_bits_left <= '0;
            r_field_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_crc_err   <= 1'b0;
            r_fsb_err   <= 1'b0;
`ifdef CAN_STUFF_CNT_CHECK_EN
            r_cnt_gray  <= '0;
            r_rx_cnt    <= '0;
            r_rx_par    <= 1'b0;
            r_stuff_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value, e.g. the FSB check sees the old r_prev_bit.
            r_done    <= 1'b0;
            r_fsb_err <= 1'b0;
            if (bus.sample_point) r_prev_bit <= bus.rx_bit;

            if (bus.abort) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_crc_err <= 1'b0;
`ifdef CAN_STUFF_CNT_CHECK_EN
                r_stuff_err <= 1'b0;
`endif
            end else if (bus.start) begin
                r_busy      <= 1'b1;
                r_crc_err   <= 1'b0;
                r_fd        <= bus.fd_frame;
                r_iso       <= bus.fd_frame & bus.fd_iso;
                r_crc_len   <= w_len;
                r_bits_left <= w_len;
                r_crc_snap  <= w_snap;
                r_rx        <= '0;
                r_field_idx <= '0;
                r_state     <= bus.fd_frame ? S_FSB : S_CRC;
`ifdef CAN_STUFF_CNT_CHECK_EN
                r_stuff_err <= 1'b0;
                r_cnt_gray  <= to_gray(bus.stuff_cnt_in);
                r_rx_cnt    <= '0;
                r_rx_par    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_FSB: if (bus.sample_point) begin
                        if (bus.rx_bit == r_prev_bit) begin
                            r_fsb_err <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state <= field_state(r_iso, r_field_idx);
                        end
                    end
                    S_SCNT, S_PAR: if (bus.sample_point) begin
`ifdef CAN_STUFF_CNT_CHECK_EN
                        if (r_state == S_SCNT) r_rx_cnt <= {r_rx_cnt[1:0], bus.rx_bit};
                        else                   r_rx_par <= bus.rx_bit;
`endif
                        r_field_idx <= w_next_idx;
                        r_state     <= w_next_fsb ? S_FSB : field_state(r_iso, w_next_idx);
                    end
                    S_CRC: if (bus.sample_point) begin
                        r_rx        <= {r_rx[19:0], bus.rx_bit};
                        r_bits_left <= r_bits_left - 5'd1;
                        r_field_idx <= w_next_idx;
                        if (r_bits_left == 5'd1)
                            r_state <= S_DONE;
                        else
                            r_state <= w_next_fsb ? S_FSB : S_CRC;
                    end
                    S_DONE: begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_crc_err <= (r_rx != r_crc_snap);
`ifdef CAN_STUFF_CNT_CHECK_EN
                        r_stuff_err <= r_iso && ((r_rx_cnt != r_cnt_gray) ||
                                                 (r_rx_par != ^r_cnt_gray));
`endif
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.crc_err = r_crc_err;
    assign bus.fsb_err = r_fsb_err;
    assign bus.crc_len = r_crc_len;
`ifdef CAN_STUFF_CNT_CHECK_EN
    assign bus.stuff_cnt_err = r_stuff_err;
`else
    assign bus.stuff_cnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_can_fd_crc_check.sv
// Self-checking bench for can_fd_crc_check: directed frames from the test
// plan followed by randomized frames, all checked against a bit-stream model
// built from the frame-format rules (Gray table, parity, FSB placement).
module tb_can_fd_crc_check;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   last_bit;

    can_fd_crc_check_if bus_if ();

    can_fd_crc_check #(.FSB_PERIOD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stuff count 0..7 in Gray code, as listed in the frame format.
    bit [2:0] gray_map [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        bus_if.sample_point = 1'b1;
        bus_if.rx_bit       = b;
        tick();
        bus_if.sample_point = 1'b0;
        last_bit            = b;
    endtask

    // One frame: start pulse, build the CRC-field bit stream from the rules,
    // send it with random gaps, then check the outcome.
    task automatic run_frame(input bit fd, input bit iso, input bit [3:0] dlc_v,
                             input bit [14:0] c15, input bit [16:0] c17, input bit [20:0] c21,
                             input bit [2:0] scnt, input bit [20:0] flip,
                             input bit use_ovr, input bit [2:0] gray_ovr,
                             input int bad_fsb, input int abort_at, input bit sp_with_start);
        int       exp_len;
        bit [20:0] calc;
        bit [20:0] tx;
        bit [2:0] g;
        bit       fb[$];
        bit       stream[$];
        bit       prev;
        bit       b;
        bit       sp_bit;
        int       fsb_no;
        int       bad_pos;
        bit       exp_se;

        exp_len = !fd ? 15 : ((dlc_v <= 4'd10) ? 17 : 21);
        calc    = (exp_len == 15) ? {6'd0, c15} : (exp_len == 17) ? {4'd0, c17} : c21;
        tx      = calc ^ flip;

        bus_if.fd_frame     = fd;
        bus_if.fd_iso       = iso;
        bus_if.dlc          = dlc_v;
        bus_if.crc_15       = c15;
        bus_if.crc_17       = c17;
        bus_if.crc_21       = c21;
        bus_if.stuff_cnt_in = scnt;
        sp_bit              = 1'($urandom);
        bus_if.sample_point = sp_with_start;
        bus_if.rx_bit       = sp_bit;
        bus_if.start        = 1'b1;
        tick();
        bus_if.start        = 1'b0;
        bus_if.sample_point = 1'b0;
        if (sp_with_start) last_bit = sp_bit;
        check("busy_after_start", bus_if.busy, 1);
        check("crc_len", bus_if.crc_len, exp_len);
        check("crc_err_cleared", bus_if.crc_err, 0);
        check("stuff_err_cleared", bus_if.stuff_cnt_err, 0);

        g = use_ovr ? gray_ovr : gray_map[scnt];
        if (fd && iso) begin
            fb.push_back(g[2]);
            fb.push_back(g[1]);
            fb.push_back(g[0]);
            fb.push_back(^gray_map[scnt]);
        end
        for (int i = exp_len - 1; i >= 0; i--) fb.push_back(tx[i]);

        prev    = last_bit;
        fsb_no  = 0;
        bad_pos = -1;
        for (int i = 0; i < fb.size(); i++) begin
            if (fd && (i % 4 == 0)) begin
                b = ~prev;
                if (fsb_no == bad_fsb) begin
                    b       = prev;
                    bad_pos = stream.size();
                end
                stream.push_back(b);
                prev = b;
                fsb_no++;
            end
            stream.push_back(fb[i]);
            prev = fb[i];
        end

`ifdef CAN_STUFF_CNT_CHECK_EN
        exp_se = fd && iso && (g != gray_map[scnt]);
`else
        exp_se = 1'b0;
`endif

        for (int k = 0; k < stream.size(); k++) begin
            if (k == abort_at) begin
                bus_if.abort = 1'b1;
                tick();
                bus_if.abort = 1'b0;
                check("abort_busy", bus_if.busy, 0);
                check("abort_crc_err", bus_if.crc_err, 0);
                check("abort_stuff_err", bus_if.stuff_cnt_err, 0);
                check("abort_done", bus_if.done, 0);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    check("abort_no_done", bus_if.done, 0);
                end
                return;
            end
            send_bit(stream[k]);
            if (k == bad_pos) begin
                check("fsb_err_pulse", bus_if.fsb_err, 1);
                check("fsb_err_busy", bus_if.busy, 0);
                check("fsb_err_done", bus_if.done, 0);
                tick();
                check("fsb_err_one_cycle", bus_if.fsb_err, 0);
                check("fsb_err_no_done", bus_if.done, 0);
                return;
            end
            if (k == stream.size() - 1) break;
            check("no_early_done", bus_if.done, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        check("done_not_yet", bus_if.done, 0);
        tick();
        check("done_pulse", bus_if.done, 1);
        check("done_busy", bus_if.busy, 0);
        check("crc_err", bus_if.crc_err, (flip != 0));
        check("stuff_cnt_err", bus_if.stuff_cnt_err, exp_se);
        check("fsb_err_quiet", bus_if.fsb_err, 0);
        tick();
        check("done_one_cycle", bus_if.done, 0);
        check("crc_err_held", bus_if.crc_err, (flip != 0));
        check("stuff_err_held", bus_if.stuff_cnt_err, exp_se);
    endtask

    initial begin
        int       len;
        bit       fd;
        bit [3:0] dl;
        bit [20:0] fl;

        n_checks = 0;
        n_fail   = 0;
        last_bit = 1'b1;
        rst_n    = 1'b0;
        bus_if.sample_point = 1'b0;
        bus_if.rx_bit       = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.fd_frame     = 1'b0;
        bus_if.fd_iso       = 1'b0;
        bus_if.dlc          = '0;
        bus_if.stuff_cnt_in = '0;
        bus_if.crc_15       = '0;
        bus_if.crc_17       = '0;
        bus_if.crc_21       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_crc_err", bus_if.crc_err, 0);
        check("rst_stuff_err", bus_if.stuff_cnt_err, 0);
        check("rst_fsb_err", bus_if.fsb_err, 0);
        check("rst_crc_len", bus_if.crc_len, 15);
        rst_n = 1'b1;
        tick();

        // Classic, dlc=8, correct CRC15.
        run_frame(0, 0, 4'd8, 15'h1A2B, 17'h0, 21'h0, 3'd0, 21'h0, 0, 3'b000, -1, -1, 0);
        // FD ISO CRC17, correct stuff count.
        run_frame(1, 1, 4'd9, 15'h0, 17'h0F0F1, 21'h0, 3'd3, 21'h0, 0, 3'b000, -1, -1, 0);
        // Same frame with stuff count bits 011.
        run_frame(1, 1, 4'd9, 15'h0, 17'h0F0F1, 21'h0, 3'd3, 21'h0, 1, 3'b011, -1, -1, 0);
        // FD ISO CRC21 with CRC bit 5 flipped.
        run_frame(1, 1, 4'd15, 15'h0, 17'h0, 21'h15A5C3, 3'd6, 21'h000020, 0, 3'b000, -1, -1, 0);
        // FD frame with the third FSB equal to the previous bit.
        run_frame(1, 1, 4'd9, 15'h0, 17'h1C3A5, 21'h0, 3'd5, 21'h0, 0, 3'b000, 2, -1, 0);
        // Abort after 6 CRC bits, then a clean classic frame.
        run_frame(0, 0, 4'd4, 15'h7ACE, 17'h0, 21'h0, 3'd0, 21'h0, 0, 3'b000, -1, 6, 0);
        run_frame(0, 0, 4'd2, 15'h0F0F, 17'h0, 21'h0, 3'd0, 21'h0, 0, 3'b000, -1, -1, 0);
        // Non-ISO FD frames, both CRC lengths.
        run_frame(1, 0, 4'd10, 15'h0, 17'h1FFFF, 21'h0, 3'd7, 21'h0, 0, 3'b000, -1, -1, 0);
        run_frame(1, 0, 4'd11, 15'h0, 17'h0, 21'h000001, 3'd1, 21'h100000, 0, 3'b000, -1, -1, 1);

        // Randomized frames.
        for (int n = 0; n < 24; n++) begin
            fd  = 1'($urandom);
            dl  = 4'($urandom);
            len = !fd ? 15 : ((dl <= 4'd10) ? 17 : 21);
            fl  = ($urandom_range(0, 1) == 1) ? (21'd1 << $urandom_range(0, len - 1)) : 21'd0;
            run_frame(fd, 1'($urandom), dl, 15'($urandom), 17'($urandom), 21'($urandom),
                      3'($urandom), fl, ($urandom_range(0, 3) == 0), 3'($urandom),
                      -1, -1, 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
